// File: rtl/seq_detect_cfg_pkg.sv
// Shared constants and helpers for the configurable serial sequence detector.
package seq_detect_pkg;

  localparam logic MODE_OVERLAP = 1'b1;
  localparam logic MODE_NONOVL  = 1'b0;

  // Width needed to hold a length in the range 0..pat_w.
  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  function automatic int len_clamp(input int len, input int pat_w);
    if (len < 1) return 1;
    if (len > pat_w) return pat_w;
    return len;
  endfunction

endpackage

// File: rtl/seq_detect_cfg_if.sv
// Config, serial data and status signals of the sequence detector.
interface seq_detect_cfg_if #(
  parameter int PAT_W = 6,
  parameter int CNT_W = 8
);
  localparam int LEN_W = seq_detect_pkg::len_w(PAT_W);

  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             data_valid;
  logic             data_in;
  logic             cnt_clr;
  logic             flag;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, data_valid, data_in, cnt_clr,
    input  flag, match_cnt
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, data_valid, data_in, cnt_clr,
    output flag, match_cnt
  );

endinterface

// File: rtl/seq_detect_cfg_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module seq_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_cfg.sv
// Runtime-configurable serial bit-sequence detector with registered hit flag
// and saturating hit counter; config load discards a coincident data sample.
module seq_detect_cfg
  import seq_detect_pkg::*;
#(
  parameter int             PAT_W   = 6,
  parameter int             CNT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = 6'b10010,
  parameter int             DEF_LEN = 5
) (
  input logic             clk,
  input logic             rst_n,
  seq_detect_cfg_if.slave bus
);

  localparam int               LEN_W   = len_w(PAT_W);
  localparam logic [LEN_W-1:0] RST_LEN = LEN_W'(len_clamp(DEF_LEN, PAT_W));
  localparam logic [LEN_W-1:0] FULL    = LEN_W'(PAT_W);

  logic [PAT_W-1:0] pat;
  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_nx;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] fill;
  logic [LEN_W-1:0] fill_nx;
  logic [LEN_W-1:0] cfg_len_c;
  logic             overlap;
  logic             sample;
  logic             match;
  logic             flag_q;

  assign sample    = bus.data_valid & ~bus.cfg_we;
  assign hist_nx   = {hist[PAT_W-2:0], bus.data_in};
  assign fill_nx   = (fill == FULL) ? fill : fill + LEN_W'(1);
  assign cfg_len_c = LEN_W'(len_clamp(int'(bus.cfg_len), PAT_W));

  // Only the low len bits take part in the compare.
  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len));
    end
  end

  assign match = sample && (fill_nx >= len) && (((hist_nx ^ pat) & mask) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat     <= DEF_PAT;
      len     <= RST_LEN;
      overlap <= MODE_OVERLAP;
      hist    <= '0;
      fill    <= '0;
      flag_q  <= 1'b0;
    end else begin
      flag_q <= match;
      if (bus.cfg_we) begin
        pat     <= bus.cfg_pattern;
        len     <= cfg_len_c;
        overlap <= bus.cfg_overlap;
        hist    <= '0;
        fill    <= '0;
      end else if (sample) begin
        hist <= hist_nx;
        // Non-overlapping mode demands a full set of fresh bits after a hit.
        fill <= (match && (overlap == MODE_NONOVL)) ? '0 : fill_nx;
      end
    end
  end

  assign bus.flag = flag_q;

  seq_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (match),
    .clr   (bus.cnt_clr),
    .cnt   (bus.match_cnt)
  );

endmodule

// File: tb/tb_seq_detect_cfg.sv
// Self-checking bench for seq_detect_cfg (PAT_W=6, CNT_W=3 so saturation is reachable).
module tb_seq_detect_cfg;

  localparam int PAT_W = 6;
  localparam int CNT_W = 3;
  localparam int CMAX  = 7;

  typedef struct {
    logic valid;
    logic din;
    logic exp_flag;
  } vec_t;

  typedef struct {
    logic             flag;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  exp_t sb[$];

  seq_detect_cfg_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  seq_detect_cfg #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  // One clock: drive inputs, record expectation, compare after the edge.
  task automatic step(input string name, input logic we, input logic [PAT_W-1:0] p,
                      input logic [2:0] l, input logic ovl, input logic v,
                      input logic d, input logic clr, input logic exp_flag);
    exp_t e;
    exp_t got;
    @(negedge clk);
    bus.cfg_we      = we;
    bus.cfg_pattern = p;
    bus.cfg_len     = l;
    bus.cfg_overlap = ovl;
    bus.data_valid  = v;
    bus.data_in     = d;
    bus.cnt_clr     = clr;
    if (clr) exp_cnt = 0;
    else if (exp_flag && exp_cnt < CMAX) exp_cnt++;
    e.flag = exp_flag;
    e.cnt  = CNT_W'(exp_cnt);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({name, "_flag"}, int'(bus.flag), int'(got.flag));
    chk({name, "_cnt"}, int'(bus.match_cnt), int'(got.cnt));
  endtask

  task automatic bit_in(input string name, input logic d, input logic exp_flag);
    step(name, 1'b0, '0, 3'd0, 1'b0, 1'b1, d, 1'b0, exp_flag);
  endtask

  task automatic gap(input string name, input logic d);
    step(name, 1'b0, '0, 3'd0, 1'b0, 1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic cfg(input string name, input logic [PAT_W-1:0] p, input logic [2:0] l,
                     input logic ovl);
    step(name, 1'b1, p, l, ovl, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t             tbl[17];
    logic [16:0]      s1;
    logic [16:0]      f1;
    logic [6:0]       s2;
    logic [6:0]       e_ov;
    logic [6:0]       e_no;

    bus.cfg_we = 1'b0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 1'b0;
    bus.data_valid = 1'b0; bus.data_in = 1'b0; bus.cnt_clr = 1'b0;

    // Default pattern 10010/len 5: hits end on bits 12 and 17 of this stream.
    s1 = 17'b0110_1101_0010_1001_0;
    f1 = 17'b0000_0000_0001_0000_1;
    for (int i = 0; i < 17; i++) begin
      tbl[i].valid    = 1'b1;
      tbl[i].din      = s1[16-i];
      tbl[i].exp_flag = f1[16-i];
    end

    #12;
    chk("rst_flag", int'(bus.flag), 0);
    chk("rst_cnt", int'(bus.match_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      step($sformatf("t1_b%0d", i + 1), 1'b0, '0, 3'd0, 1'b0, tbl[i].valid, tbl[i].din,
           1'b0, tbl[i].exp_flag);
    end
    chk("t1_total", int'(bus.match_cnt), 2);

    s2   = 7'b1011011;
    e_ov = 7'b0001001;
    e_no = 7'b0001000;
    cfg("t2o_cfg", 6'b001011, 3'd4, 1'b1);
    for (int i = 0; i < 7; i++) bit_in($sformatf("t2o_b%0d", i + 1), s2[6-i], e_ov[6-i]);
    chk("t2o_total", int'(bus.match_cnt), 2);
    cfg("t2n_cfg", 6'b001011, 3'd4, 1'b0);
    for (int i = 0; i < 7; i++) bit_in($sformatf("t2n_b%0d", i + 1), s2[6-i], e_no[6-i]);
    chk("t2n_total", int'(bus.match_cnt), 1);

    cfg("t3_cfg", 6'b000101, 3'd3, 1'b1);
    bit_in("t3_b1", 1'b1, 1'b0);
    for (int g = 0; g < 3; g++) gap("t3_g1", g[0]);
    bit_in("t3_b2", 1'b0, 1'b0);
    for (int g = 0; g < 3; g++) gap("t3_g2", ~g[0]);
    bit_in("t3_b3", 1'b1, 1'b1);
    gap("t3_after", 1'b1);

    cfg("t4_cfg0", 6'b001011, 3'd4, 1'b1);
    bit_in("t4_b1", 1'b1, 1'b0);
    bit_in("t4_b2", 1'b0, 1'b0);
    step("t4_cfg1", 1'b1, 6'b000011, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    bit_in("t4_b3", 1'b1, 1'b0);
    bit_in("t4_b4", 1'b1, 1'b1);

    // Length above PAT_W clamps to PAT_W.
    cfg("t5_cfgmax", 6'b111111, 3'd7, 1'b1);
    for (int i = 0; i < 7; i++) bit_in($sformatf("t5m_b%0d", i + 1), 1'b1, i >= 5);
    cfg("t5_cfg0", 6'b000001, 3'd0, 1'b1);
    for (int i = 0; i < 9; i++) bit_in($sformatf("t5z_b%0d", i + 1), 1'b1, 1'b1);
    chk("t5_sat", int'(bus.match_cnt), 7);
    bit_in("t5z_zero", 1'b0, 1'b0);
    step("t5_clr_hit", 1'b0, '0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

    cfg("t6_cfg", 6'b001011, 3'd4, 1'b1);
    bit_in("t6_b1", 1'b1, 1'b0);
    bit_in("t6_b2", 1'b0, 1'b0);
    bit_in("t6_b3", 1'b1, 1'b0);
    bit_in("t6_b4", 1'b1, 1'b1);
    bit_in("t6_b5", 1'b0, 1'b0);
    bit_in("t6_b6", 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk("t6_rst_flag", int'(bus.flag), 0);
    chk("t6_rst_cnt", int'(bus.match_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bit_in("t6_b7", 1'b1, 1'b0);
    bit_in("t6_b8", 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
